// File: rtl/ctrl_fsm_v2_pkg.sv
// Shared types, encodings and elaboration helpers for the ctrl_fsm_v2 sequencer.
package ctrl_fsm_v2_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned CAUSE_W = 3;

   // Sequencer states; encodings are visible on the state port.
   typedef enum logic [STATE_W-1:0] {
      S_FETCH      = 3'd0,
      S_DECODE     = 3'd1,
      S_EXECUTE    = 3'd2,
      S_WRITE_BACK = 3'd3,
      S_MEM_WAIT   = 3'd4,
      S_TRAP       = 3'd5,
      S_DIV_WAIT   = 3'd6,
      S_HALT       = 3'd7
   } state_e;

   // Trap cause codes latched on entry to TRAP.
   localparam logic [CAUSE_W-1:0] CAUSE_NONE        = 3'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL     = 3'd1;
   localparam logic [CAUSE_W-1:0] CAUSE_MEM_FAULT   = 3'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_MEM_TIMEOUT = 3'd3;
   localparam logic [CAUSE_W-1:0] CAUSE_DIV_TIMEOUT = 3'd4;
   localparam logic [CAUSE_W-1:0] CAUSE_IRQ         = 3'd5;

   // Ceiling log2; clog2(0) = clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ctrl_fsm_v2_wait_timer.sv
// Wait-state cycle counter shared by DIV_WAIT and MEM_WAIT; flags the last allowed cycle.
module ctrl_fsm_v2_wait_timer #(
   parameter int unsigned WIDTH = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             expired_c
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Clear has priority; otherwise count while the wait continues.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A zero limit disables expiry; otherwise the limit-th wait cycle is the last one.
   assign expired_c = (limit != '0) && (cnt_q == (limit - WIDTH'(1)));

endmodule

// File: rtl/ctrl_fsm_v2.sv
// Multi-cycle control sequencer: fetch/decode/execute/writeback with wait states, traps and halt.
module ctrl_fsm_v2
   import ctrl_fsm_v2_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned DIV_TIMEOUT = 40,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned IRQ_EN      = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               fetch_valid,
   input  logic               decoder_illegal,
   input  logic               is_div,
   input  logic               is_load_store,
   input  logic               div_busy,
   input  logic               mem_busy,
   input  logic               mem_fault,
   input  logic               irq_pending,
   input  logic               halt_req,
   output logic [STATE_W-1:0] state,
   output logic               pc_we,
   output logic               rf_we,
   output logic               trap_taken,
   output logic [CAUSE_W-1:0] trap_cause,
   output logic               halted,
   output logic [CNT_W-1:0]   instret
);

   localparam int unsigned TMR_W  = clog2(max2(MEM_TIMEOUT, DIV_TIMEOUT)) + 1;
   localparam logic        IRQ_ON = (IRQ_EN != 0);

   state_e             state_q, state_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [CNT_W-1:0]   instret_q, instret_d;
   logic               pc_we_q, pc_we_d;
   logic               rf_we_q, rf_we_d;
   logic               trap_taken_q, trap_taken_d;
   logic               halted_q, halted_d;

   logic               tmr_clear;
   logic               tmr_enable;
   logic [TMR_W-1:0]   tmr_limit;
   logic               tmr_expired_c;

   // One timer serves both wait states; the limit follows whichever wait is active.
   assign tmr_limit = (state_q == S_DIV_WAIT) ? TMR_W'(DIV_TIMEOUT) : TMR_W'(MEM_TIMEOUT);

   ctrl_fsm_v2_wait_timer #(
      .WIDTH (TMR_W)
   ) u_wait_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (tmr_clear),
      .enable    (tmr_enable),
      .limit     (tmr_limit),
      .expired_c (tmr_expired_c)
   );

   // Next-state, trap cause, retire count and timer control.
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      instret_d  = instret_q;
      tmr_clear  = 1'b0;
      tmr_enable = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            if (halt_req) begin
               state_d = S_HALT;
            end else if (IRQ_ON && irq_pending) begin
               state_d = S_TRAP;
               cause_d = CAUSE_IRQ;
            end else if (fetch_valid) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (decoder_illegal) begin
               state_d = S_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            if (is_div) begin
               state_d   = S_DIV_WAIT;
               tmr_clear = 1'b1;
            end else if (is_load_store) begin
               state_d   = S_MEM_WAIT;
               tmr_clear = 1'b1;
            end else begin
               state_d = S_WRITE_BACK;
            end
         end
         S_DIV_WAIT: begin
            if (!div_busy) begin
               state_d = S_WRITE_BACK;
            end else if (tmr_expired_c) begin
               state_d = S_TRAP;
               cause_d = CAUSE_DIV_TIMEOUT;
            end else begin
               tmr_enable = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            if (mem_fault) begin
               state_d = S_TRAP;
               cause_d = CAUSE_MEM_FAULT;
            end else if (!mem_busy) begin
               state_d = S_WRITE_BACK;
            end else if (tmr_expired_c) begin
               state_d = S_TRAP;
               cause_d = CAUSE_MEM_TIMEOUT;
            end else begin
               tmr_enable = 1'b1;
            end
         end
         S_WRITE_BACK: begin
            instret_d = instret_q + CNT_W'(1);
            state_d   = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_FETCH;
         end
         S_HALT: begin
            if (!halt_req) state_d = S_FETCH;
         end
      endcase
   end

   // Output flags are computed from the next state so they register in step with it.
   always_comb begin
      pc_we_d      = (state_d == S_WRITE_BACK) || (state_d == S_TRAP);
      rf_we_d      = (state_d == S_WRITE_BACK);
      trap_taken_d = (state_d == S_TRAP);
      halted_d     = (state_d == S_HALT);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_FETCH;
         cause_q      <= CAUSE_NONE;
         instret_q    <= '0;
         pc_we_q      <= 1'b0;
         rf_we_q      <= 1'b0;
         trap_taken_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cause_q      <= cause_d;
         instret_q    <= instret_d;
         pc_we_q      <= pc_we_d;
         rf_we_q      <= rf_we_d;
         trap_taken_q <= trap_taken_d;
         halted_q     <= halted_d;
      end
   end

   assign state      = state_q;
   assign pc_we      = pc_we_q;
   assign rf_we      = rf_we_q;
   assign trap_taken = trap_taken_q;
   assign trap_cause = cause_q;
   assign halted     = halted_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_ctrl_fsm_v2.sv
// Directed bench for ctrl_fsm_v2: one DUT with short timeouts and a 4-bit counter, one with IRQ disabled.
module tb_ctrl_fsm_v2;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic fetch_valid = 1'b0;
   logic decoder_illegal = 1'b0;
   logic is_div = 1'b0;
   logic is_load_store = 1'b0;
   logic div_busy = 1'b0;
   logic mem_busy = 1'b0;
   logic mem_fault = 1'b0;
   logic irq_pending = 1'b0;
   logic halt_req = 1'b0;

   logic [2:0]  state;
   logic        pc_we, rf_we, trap_taken, halted;
   logic [2:0]  trap_cause;
   logic [3:0]  instret;

   logic [2:0]  n_state;
   logic        n_pc_we, n_rf_we, n_trap_taken, n_halted;
   logic [2:0]  n_trap_cause;
   logic [31:0] n_instret;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ctrl_fsm_v2 #(
      .MEM_TIMEOUT (8),
      .DIV_TIMEOUT (5),
      .CNT_W       (4),
      .IRQ_EN      (1)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .fetch_valid     (fetch_valid),
      .decoder_illegal (decoder_illegal),
      .is_div          (is_div),
      .is_load_store   (is_load_store),
      .div_busy        (div_busy),
      .mem_busy        (mem_busy),
      .mem_fault       (mem_fault),
      .irq_pending     (irq_pending),
      .halt_req        (halt_req),
      .state           (state),
      .pc_we           (pc_we),
      .rf_we           (rf_we),
      .trap_taken      (trap_taken),
      .trap_cause      (trap_cause),
      .halted          (halted),
      .instret         (instret)
   );

   ctrl_fsm_v2 #(
      .IRQ_EN (0)
   ) dut_n (
      .clk             (clk),
      .reset_n         (reset_n),
      .fetch_valid     (fetch_valid),
      .decoder_illegal (decoder_illegal),
      .is_div          (is_div),
      .is_load_store   (is_load_store),
      .div_busy        (div_busy),
      .mem_busy        (mem_busy),
      .mem_fault       (mem_fault),
      .irq_pending     (irq_pending),
      .halt_req        (halt_req),
      .state           (n_state),
      .pc_we           (n_pc_we),
      .rf_we           (n_rf_we),
      .trap_taken      (n_trap_taken),
      .trap_cause      (n_trap_cause),
      .halted          (n_halted),
      .instret         (n_instret)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From FETCH, bring one instruction to EXECUTE.
   task automatic to_execute();
      fetch_valid = 1'b1;
      tick();
      chk("to_decode", 32'(state), 32'd1);
      fetch_valid = 1'b0;
      tick();
      chk("to_execute", 32'(state), 32'd2);
   endtask

   initial begin
      // Reset
      #1 reset_n = 1'b0;
      tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cause", 32'(trap_cause), 32'd0);
      chk("rst_instret", 32'(instret), 32'd0);
      chk("rst_pc_we", 32'(pc_we), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_trap", 32'(trap_taken), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("idle_fetch", 32'(state), 32'd0);

      // ALU op: 0,1,2,3,0
      to_execute();
      chk("alu_ex_rf_we", 32'(rf_we), 32'd0);
      tick();
      chk("alu_wb", 32'(state), 32'd3);
      chk("alu_wb_rf_we", 32'(rf_we), 32'd1);
      chk("alu_wb_pc_we", 32'(pc_we), 32'd1);
      chk("alu_wb_instret", 32'(instret), 32'd0);
      tick();
      chk("alu_fetch", 32'(state), 32'd0);
      chk("alu_rf_we_off", 32'(rf_we), 32'd0);
      chk("alu_instret", 32'(instret), 32'd1);

      // Illegal opcode
      fetch_valid = 1'b1;
      tick();
      chk("ill_decode", 32'(state), 32'd1);
      fetch_valid = 1'b0;
      decoder_illegal = 1'b1;
      tick();
      decoder_illegal = 1'b0;
      chk("ill_trap", 32'(state), 32'd5);
      chk("ill_trap_taken", 32'(trap_taken), 32'd1);
      chk("ill_cause", 32'(trap_cause), 32'd1);
      chk("ill_pc_we", 32'(pc_we), 32'd1);
      chk("ill_rf_we", 32'(rf_we), 32'd0);
      tick();
      chk("ill_fetch", 32'(state), 32'd0);
      chk("ill_trap_off", 32'(trap_taken), 32'd0);
      chk("ill_cause_held", 32'(trap_cause), 32'd1);
      chk("ill_instret", 32'(instret), 32'd1);

      // MEM op, busy for 3 wait cycles
      to_execute();
      is_load_store = 1'b1;
      mem_busy = 1'b1;
      tick();
      is_load_store = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("mem_wait", 32'(state), 32'd4);
         if (i == 2) mem_busy = 1'b0;
         tick();
      end
      chk("mem_wb", 32'(state), 32'd3);
      tick();
      chk("mem_instret", 32'(instret), 32'd2);

      // MEM timeout after exactly 8 wait cycles
      to_execute();
      is_load_store = 1'b1;
      mem_busy = 1'b1;
      tick();
      is_load_store = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("memto_wait", 32'(state), 32'd4);
         tick();
      end
      chk("memto_trap", 32'(state), 32'd5);
      chk("memto_cause", 32'(trap_cause), 32'd3);
      mem_busy = 1'b0;
      tick();
      chk("memto_instret", 32'(instret), 32'd2);

      // Fault beats completion
      to_execute();
      is_load_store = 1'b1;
      mem_busy = 1'b1;
      tick();
      is_load_store = 1'b0;
      chk("flt_wait", 32'(state), 32'd4);
      mem_fault = 1'b1;
      mem_busy = 1'b0;
      tick();
      mem_fault = 1'b0;
      chk("flt_trap", 32'(state), 32'd5);
      chk("flt_cause", 32'(trap_cause), 32'd2);
      chk("flt_rf_we", 32'(rf_we), 32'd0);
      tick();
      chk("flt_fetch", 32'(state), 32'd0);
      chk("flt_instret", 32'(instret), 32'd2);

      // Divide completes after 2 wait cycles; div wins over load/store
      to_execute();
      is_div = 1'b1;
      is_load_store = 1'b1;
      div_busy = 1'b1;
      tick();
      is_div = 1'b0;
      is_load_store = 1'b0;
      chk("div_wait0", 32'(state), 32'd6);
      tick();
      chk("div_wait1", 32'(state), 32'd6);
      div_busy = 1'b0;
      tick();
      chk("div_wb", 32'(state), 32'd3);
      tick();
      chk("div_instret", 32'(instret), 32'd3);

      // Divide timeout after exactly 5 wait cycles
      to_execute();
      is_div = 1'b1;
      div_busy = 1'b1;
      tick();
      is_div = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("divto_wait", 32'(state), 32'd6);
         tick();
      end
      chk("divto_trap", 32'(state), 32'd5);
      chk("divto_cause", 32'(trap_cause), 32'd4);
      div_busy = 1'b0;
      tick();
      chk("divto_instret", 32'(instret), 32'd3);

      // Re-align both DUTs
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      chk("rst2_instret", 32'(instret), 32'd0);

      // IRQ raised in EXECUTE: retire first, trap at next FETCH
      to_execute();
      irq_pending = 1'b1;
      tick();
      chk("irq_wb", 32'(state), 32'd3);
      tick();
      chk("irq_fetch", 32'(state), 32'd0);
      chk("irq_instret", 32'(instret), 32'd1);
      tick();
      chk("irq_trap", 32'(state), 32'd5);
      chk("irq_cause", 32'(trap_cause), 32'd5);
      chk("irq_trap_instret", 32'(instret), 32'd1);
      chk("noirq_state", 32'(n_state), 32'd0);
      chk("noirq_trap", 32'(n_trap_taken), 32'd0);
      chk("noirq_cause", 32'(n_trap_cause), 32'd0);
      chk("noirq_pc_we", 32'(n_pc_we), 32'd0);
      chk("noirq_rf_we", 32'(n_rf_we), 32'd0);
      chk("noirq_halted", 32'(n_halted), 32'd0);
      chk("noirq_instret", n_instret, 32'd1);
      irq_pending = 1'b0;
      tick();
      chk("irq_back", 32'(state), 32'd0);

      // Halt requested in EXECUTE; irq ignored while halted
      to_execute();
      halt_req = 1'b1;
      tick();
      chk("halt_wb", 32'(state), 32'd3);
      tick();
      chk("halt_fetch", 32'(state), 32'd0);
      chk("halt_fetch_instret", 32'(instret), 32'd2);
      irq_pending = 1'b1;
      tick();
      chk("halt_state", 32'(state), 32'd7);
      chk("halt_halted", 32'(halted), 32'd1);
      tick();
      chk("halt_hold", 32'(state), 32'd7);
      chk("halt_no_trap", 32'(trap_taken), 32'd0);
      halt_req = 1'b0;
      irq_pending = 1'b0;
      tick();
      chk("halt_release", 32'(state), 32'd0);
      chk("halt_off", 32'(halted), 32'd0);

      // 4-bit instret wrap: 14 more ALU retires (2 + 14 = 16)
      fetch_valid = 1'b1;
      for (int i = 0; i < 13 * 4; i++) tick();
      chk("wrap_pre", 32'(instret), 32'd15);
      for (int i = 0; i < 4; i++) tick();
      fetch_valid = 1'b0;
      chk("wrap_state", 32'(state), 32'd0);
      chk("wrap_instret", 32'(instret), 32'd0);

      // Asynchronous reset in DIV_WAIT
      to_execute();
      is_div = 1'b1;
      div_busy = 1'b1;
      tick();
      is_div = 1'b0;
      chk("areset_wait", 32'(state), 32'd6);
      #2 reset_n = 1'b0;
      #1;
      chk("areset_state", 32'(state), 32'd0);
      chk("areset_trap", 32'(trap_taken), 32'd0);
      chk("areset_cause", 32'(trap_cause), 32'd0);
      div_busy = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      chk("areset_after", 32'(state), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
